// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response and word-RAM signal bundle for dmem_lsu
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        rsp_valid;
  logic        rsp_fault;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;

  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // master is the requester plus the RAM; slave is the load/store unit
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, rsp_valid, rsp_fault, rsp_write, rsp_rdata, rsp_rd,
    input  mem_write, mem_funct3, mem_rd, mem_address, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, rsp_valid, rsp_fault, rsp_write, rsp_rdata, rsp_rd,
    output mem_write, mem_funct3, mem_rd, mem_address, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit in front of a word-addressed data RAM
// Sub-word stores are read-modify-write; loads are lane-selected and extended here.
module dmem_lsu #(
  parameter int WORD_ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, LOAD, RESP} state_t;

  state_t                   state;
  logic [WORD_ADDR_W+1:0]   addr_q;
  logic [2:0]               funct3_q;
  logic [31:0]              wdata_q;
  logic [31:0]              merge_q;
  logic [4:0]               rd_q;
  logic                     write_q;

  logic                     req_fault;
  logic [31:0]              lane_shift;
  logic [31:0]              load_data;
  logic [31:0]              store_word;

  // Illegal funct3 first, then alignment by access size (funct3[1:0])
  always_comb begin
    req_fault = 1'b0;
    if (bus.req_write)
      req_fault = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    else
      req_fault = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    case (bus.req_funct3[1:0])
      2'b01:   if (bus.req_addr[0]) req_fault = 1'b1;
      2'b10:   if (bus.req_addr[1:0] != 2'b00) req_fault = 1'b1;
      default: ;
    endcase
  end

  assign lane_shift = bus.mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = lane_shift;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_shift[7]}},  lane_shift[7:0]};
      3'b001:  load_data = {{16{lane_shift[15]}}, lane_shift[15:0]};
      3'b100:  load_data = {24'b0, lane_shift[7:0]};
      3'b101:  load_data = {16'b0, lane_shift[15:0]};
      default: load_data = lane_shift;
    endcase
  end

  // Only the addressed byte/half lane is replaced; the rest comes from the READ snapshot
  always_comb begin
    store_word = wdata_q;
    if (funct3_q[1:0] == 2'b00) begin
      store_word = merge_q;
      store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (funct3_q[1:0] == 2'b01) begin
      store_word = merge_q;
      if (addr_q[1])
        store_word[31:16] = wdata_q[15:0];
      else
        store_word[15:0] = wdata_q[15:0];
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.mem_write   = (state == WRITE);
  assign bus.mem_funct3  = 3'b010;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_address = (state == IDLE) ? 32'd0
                         : {{(32-WORD_ADDR_W){1'b0}}, addr_q[WORD_ADDR_W+1:2]};
  assign bus.mem_wdata   = (state == WRITE) ? store_word : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      funct3_q      <= 3'b0;
      wdata_q       <= 32'd0;
      merge_q       <= 32'd0;
      rd_q          <= 5'd0;
      write_q       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_fault <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_rd    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr[WORD_ADDR_W+1:0];
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
            rd_q     <= bus.req_rd;
            write_q  <= bus.req_write;
            if (req_fault) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= 1'b1;
              bus.rsp_write <= bus.req_write;
              bus.rsp_rdata <= 32'd0;
              bus.rsp_rd    <= bus.req_rd;
            end else if (!bus.req_write) begin
              state <= LOAD;
            end else if (bus.req_funct3[1:0] == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          merge_q <= bus.mem_rdata;
          state   <= WRITE;
        end
        WRITE: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_fault <= 1'b0;
          bus.rsp_write <= write_q;
          bus.rsp_rdata <= 32'd0;
          bus.rsp_rd    <= rd_q;
        end
        LOAD: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_fault <= 1'b0;
          bus.rsp_write <= write_q;
          bus.rsp_rdata <= load_data;
          bus.rsp_rd    <= rd_q;
        end
        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu against a byte-level model
module tb_dmem_lsu;

  typedef struct {
    logic        fault;
    logic        write;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          lat;
    int          nwr;
    logic [7:0]  widx;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ram_init;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_seen = 0;
  logic [31:0] last_rdata;
  logic        last_fault;

  logic [31:0] ram [256];
  logic [31:0] ref_ram [256];
  exp_t        q [$];

  dmem_lsu_if bus ();

  dmem_lsu #(.WORD_ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E3779B9) ^ 32'h13572468;
  endfunction

  assign bus.mem_rdata = ram[bus.mem_address[7:0]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (bus.mem_write) begin
      ram[bus.mem_address[7:0]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed view of the word RAM, RV32I rules applied directly
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, output exp_t e);
    int          size, off, idx;
    logic        illegal;
    logic [31:0] word;
    longint      v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (w) illegal = (f3 > 3'd2);
    else   illegal = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    off  = int'(a[1:0]);
    idx  = int'((a / 4) % 256);
    e.fault = illegal || ((off % size) != 0);
    e.write = w;
    e.rd    = rd;
    e.widx  = 8'(idx);
    e.rdata = 32'd0;
    e.nwr   = 0;
    word    = ref_ram[idx];
    if (e.fault) begin
      e.lat = 1;
    end else if (!w) begin
      e.lat = 2;
      v = longint'(word >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
      if (f3 < 3'd4 && size < 4 && v >= (64'd1 << (8 * size - 1)))
        v = v - (64'd1 << (8 * size));
      e.rdata = v[31:0];
    end else begin
      e.lat = (size < 4) ? 3 : 2;
      e.nwr = 1;
      for (int b = 0; b < size; b++) word[8 * (off + b) +: 8] = wd[8 * b +: 8];
      ref_ram[idx] = word;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.mem_write) begin
        wr_seen++;
        if (q.size() == 0) begin
          chk("stray_write", {31'b0, bus.mem_write}, 32'd0);
        end else begin
          chk("mem_address", bus.mem_address, {24'b0, q[0].widx});
          chk("mem_rd", {27'b0, bus.mem_rd}, {27'b0, q[0].rd});
          chk("mem_funct3", {29'b0, bus.mem_funct3}, 32'd2);
        end
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_fault", {31'b0, bus.rsp_fault}, {31'b0, e.fault});
          chk("rsp_write", {31'b0, bus.rsp_write}, {31'b0, e.write});
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_rd", {27'b0, bus.rsp_rd}, {27'b0, e.rd});
          chk("latency", cyc - e.t0, e.lat);
          chk("write_count", wr_seen, e.nwr);
          chk("ram_word", ram[e.widx], ref_ram[e.widx]);
          last_rdata = bus.rsp_rdata;
          last_fault = bus.rsp_fault;
        end
        wr_seen = 0;
      end
    end
  end

  task automatic check_idle_outputs();
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_fault", {31'b0, bus.rsp_fault}, 32'd0);
    chk("rst_rsp_write", {31'b0, bus.rsp_write}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_rd", {27'b0, bus.rsp_rd}, 32'd0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_rd", {27'b0, bus.mem_rd}, 32'd0);
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'b0, bus.req_ready}, 32'd1);
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input bit junk);
    exp_t e;
    wait_ready();
    model(w, f3, a, wd, rd, e);
    e.t0 = cyc;
    q.push_back(e);
    drive(w, f3, a, wd, rd);
    @(posedge clk);
    #1;
    chk("ready_busy", {31'b0, bus.req_ready}, 32'd0);
    // A held/changed request while busy must be ignored
    if (junk) begin
      drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", q.size(), 32'd0);
  endtask

  task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] rd);
    issue(w, f3, a, wd, rd, 1'b0);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int i = 0; i < 256; i++) ref_ram[i] = init_val(i);
    rst = 1'b1;
    ram_init = 1'b1;
    bus.req_valid = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs();
    chk("rst_mem_funct3", {29'b0, bus.mem_funct3}, 32'd2);
    ram_init = 1'b0;
    rst = 1'b0;

    run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd1);
    chk("lit_sw_word4", ram[4], 32'hDEADBEEF);
    run(1'b0, 3'd2, 32'h10, 32'h0, 5'd2);
    chk("lit_lw", last_rdata, 32'hDEADBEEF);
    run(1'b1, 3'd0, 32'h11, 32'h00000055, 5'd3);
    chk("lit_sb_word4", ram[4], 32'hDEAD55EF);
    run(1'b0, 3'd0, 32'h11, 32'h0, 5'd4);
    chk("lit_lb_11", last_rdata, 32'h00000055);
    run(1'b0, 3'd4, 32'h13, 32'h0, 5'd5);
    chk("lit_lbu_13", last_rdata, 32'h000000DE);
    run(1'b0, 3'd0, 32'h13, 32'h0, 5'd6);
    chk("lit_lb_13", last_rdata, 32'hFFFFFFDE);
    run(1'b1, 3'd1, 32'h12, 32'h00008001, 5'd7);
    chk("lit_sh_word4", ram[4], 32'h800155EF);
    run(1'b0, 3'd1, 32'h12, 32'h0, 5'd8);
    chk("lit_lh_12", last_rdata, 32'hFFFF8001);
    run(1'b0, 3'd5, 32'h12, 32'h0, 5'd9);
    chk("lit_lhu_12", last_rdata, 32'h00008001);
    run(1'b0, 3'd2, 32'h0A, 32'h0, 5'd10);
    chk("lit_fault_lw", {31'b0, last_fault}, 32'd1);
    run(1'b1, 3'd1, 32'h07, 32'h1234, 5'd11);
    chk("lit_fault_sh", {31'b0, last_fault}, 32'd1);
    run(1'b0, 3'd3, 32'h20, 32'h0, 5'd12);
    chk("lit_fault_f3", {31'b0, last_fault}, 32'd1);
    chk("lit_fault_rdata", last_rdata, 32'd0);
    run(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 5'd13);
    chk("lit_wrap_word0", ram[0], 32'hCAFEF00D);

    // Reset while an SB is in its READ cycle: dropped with no response or write
    saved = ram[16];
    wait_ready();
    drive(1'b1, 3'd0, 32'h41, 32'h77, 5'd14);
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rmw_word", ram[16], saved);
    run(1'b0, 3'd2, 32'h40, 32'h0, 5'd15);
    chk("lit_lw_after_rst", last_rdata, saved);

    for (int i = 0; i < 400; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (w && f3 == 3'd3) f3 = 3'd2;
      if (w && f3 > 3'd3 && $urandom_range(0, 3) != 0) f3 = f3 - 3'd4;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 63));
      issue(w, f3, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
